// File: rtl/line_pingpong_ctrl.sv
// line_pingpong_ctrl: runs one 2048x8 dual-port RAM as a two-bank ping-pong line buffer
// with a valid/ready output stream fed through a 2-entry FIFO.
module line_pingpong_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int LINE_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              trunc_err
);
  localparam int CW = ADDR_W - 1;
  // bit 1 of the write state is s_ready, so the output comes straight from a flop
  typedef enum logic [1:0] {W_INIT = 2'b00, W_WAIT = 2'b01, W_FILL = 2'b10, W_DROP = 2'b11} w_state_t;
  typedef enum logic {R_IDLE, R_RUN} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic wr_bank, rd_bank, infl, infl_last, wp, rp;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [1:0] full, full_n, fcnt;
  logic [ADDR_W-1:0] len [2];
  logic [DATA_W:0] fifo [2];
  logic acc, line_end, issue, rd_end, pop;

  assign acc = s_valid && s_ready;
  assign line_end = acc && w_state == W_FILL && (s_last || wr_cnt == CW'(LINE_MAX - 1));
  assign pop = m_valid && m_ready;
  // a pop in the same cycle frees a slot, which keeps the stream at one beat per cycle
  assign issue = r_state == R_RUN && ({1'b0, fcnt} + {2'b0, infl}) < ({2'b0, pop} + 3'd2);
  assign rd_end = issue && ADDR_W'(rd_cnt) == len[rd_bank] - ADDR_W'(1);

  always_comb begin
    full_n = full;
    if (rd_end) full_n[rd_bank] = 1'b0;
    if (line_end) full_n[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_INIT;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_INIT: w_next = W_FILL;
      W_FILL: if (line_end) w_next = !s_last ? W_DROP : full_n[!wr_bank] ? W_WAIT : W_FILL;
      W_DROP: if (acc && s_last) w_next = full_n[wr_bank] ? W_WAIT : W_FILL;
      W_WAIT: if (!full[wr_bank]) w_next = W_FILL;
    endcase
    r_next = r_state == R_IDLE ? (full[rd_bank] ? R_RUN : R_IDLE) : (rd_end ? R_IDLE : R_RUN);
  end

  always_comb begin
    s_ready = w_state[1];
    ram_wr_en = acc && w_state == W_FILL;
    ram_wr_addr = {wr_bank, wr_cnt};
    ram_wr_data = s_data;
    trunc_err = line_end && !s_last;
    ram_rd_addr = {rd_bank, rd_cnt};
    m_valid = fcnt != 2'd0;
    m_data = fifo[rp][DATA_W-1:0];
    m_last = m_valid && fifo[rp][DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      len[0] <= '0;
      len[1] <= '0;
      infl <= 1'b0;
      infl_last <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      fcnt <= '0;
    end else begin
      full <= full_n;
      if (ram_wr_en) wr_cnt <= line_end ? '0 : wr_cnt + CW'(1);
      if (line_end) begin
        len[wr_bank] <= ADDR_W'(wr_cnt) + ADDR_W'(1);
        wr_bank <= !wr_bank;
      end
      if (r_state == R_IDLE) rd_cnt <= '0;
      else if (issue) rd_cnt <= rd_cnt + CW'(1);
      if (rd_end) rd_bank <= !rd_bank;
      infl <= issue;
      infl_last <= rd_end;
      if (infl) begin
        fifo[wp] <= {infl_last, ram_rd_data};
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      fcnt <= fcnt + {1'b0, infl} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_line_pingpong_ctrl.sv
// tb_line_pingpong_ctrl: table-driven line vectors plus hand-written corner sequences,
// with a behavioural RAM and an output scoreboard.
module tb_line_pingpong_ctrl;
  typedef struct {
    int n;
    bit last_end;
    int vpct;
    int rpct;
    int trunc;
    bit watch;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic s_ready, m_valid, m_last, ram_wr_en, trunc_err;
  logic [7:0] m_data, ram_wr_data, ram_rd_data, prev_d;
  logic [10:0] ram_wr_addr, ram_rd_addr, ram_rd_q;
  logic [7:0] ram [2048];
  logic [8:0] exp_q [$];
  vec_t vecs [6];
  int n_cmp = 0, n_bad = 0, rdy_pct = 0, line_idx = 0, trunc_cnt = 0, sr_low = 0;
  int t0, s0, edges, t99;
  bit wb = 1'b0, watch_sr = 1'b0, prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, lb, mv, rose;

  line_pingpong_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_q <= ram_rd_addr;
  end
  assign ram_rd_data = ram[ram_rd_q];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1 m_ready = ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin
    if (!rst_n) prev_v <= 1'b0;
    else begin
      if (prev_v && !prev_r) begin
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_data", m_data, prev_d);
        chk("stall_m_last", m_last, prev_l);
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("m_data", m_data, exp_q[0][7:0]);
          chk("m_last", m_last, exp_q[0][8]);
          void'(exp_q.pop_front());
        end
      end
      if (trunc_err) trunc_cnt <= trunc_cnt + 1;
      if (watch_sr && !s_ready) sr_low <= sr_low + 1;
      prev_v <= m_valid;
      prev_r <= m_ready;
      prev_d <= m_data;
      prev_l <= m_last;
    end
  end

  task automatic send_line(input int n, input bit last_end, input int vpct);
    int i = 0;
    int idle = 0;
    while (i < n && idle < 5000) begin
      s_valid = ($urandom_range(99) < vpct);
      s_data = 8'($urandom);
      s_last = last_end && (i == n - 1);
      @(negedge clk);
      if (s_valid && s_ready) begin
        if (line_idx < 1024) begin
          exp_q.push_back({s_last || line_idx == 1023, s_data});
          chk("wr_en", ram_wr_en, 1);
          chk("wr_addr", ram_wr_addr, {wb, 10'(line_idx)});
          chk("wr_data", ram_wr_data, s_data);
          chk("trunc_err", trunc_err, line_idx == 1023 && !s_last);
          if (s_last || line_idx == 1023) wb = !wb;
        end else begin
          chk("drop_wr_en", ram_wr_en, 0);
          chk("drop_trunc_err", trunc_err, 0);
        end
        line_idx = s_last ? 0 : line_idx + 1;
        i++;
        idle = 0;
      end else idle++;
      @(posedge clk);
      #1;
    end
    chk("send_done", i, n);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 5000 && exp_q.size() != 0; k++) @(posedge clk);
    #1 chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{640, 1'b1, 100, 100, 0, 1'b1};
    vecs[1] = '{640, 1'b1, 100, 100, 0, 1'b1};
    vecs[2] = '{1030, 1'b1, 100, 100, 1, 1'b0};
    vecs[3] = '{1024, 1'b1, 100, 100, 0, 1'b0};
    vecs[4] = '{1, 1'b1, 100, 50, 0, 1'b0};
    vecs[5] = '{1, 1'b1, 60, 100, 0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    chk("rst_trunc", trunc_err, 0);
    rst_n = 1'b1;
    chk("init_s_ready", s_ready, 0);
    @(posedge clk);
    #1 chk("fill_s_ready", s_ready, 1);

    foreach (vecs[v]) begin
      rdy_pct = vecs[v].rpct;
      t0 = trunc_cnt;
      s0 = sr_low;
      watch_sr = vecs[v].watch;
      send_line(vecs[v].n, vecs[v].last_end, vecs[v].vpct);
      watch_sr = 1'b0;
      chk("trunc_pulses", trunc_cnt - t0, vecs[v].trunc);
      if (vecs[v].watch) chk("s_ready_low_cycles", sr_low - s0, 0);
    end
    drain();

    rdy_pct = 100;
    repeat (2) @(posedge clk);
    #1 send_line(5, 1'b1, 100);
    edges = 0;
    mv = 1'b0;
    while (!mv && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      mv = m_valid;
    end
    chk("first_valid_latency", edges, 3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stream_valid", m_valid, 1);
      chk("stream_last", m_last, k == 4);
    end
    drain();

    rdy_pct = 0;
    repeat (2) @(posedge clk);
    #1 lb = wb;
    send_line(100, 1'b1, 100);
    send_line(100, 1'b1, 100);
    fork
      send_line(100, 1'b1, 100);
      begin
        t99 = -100;
        rose = 1'b0;
        repeat (5) @(negedge clk);
        chk("s_ready_in_wait", s_ready, 0);
        chk("m_valid_held", m_valid, 1);
        rdy_pct = 100;
        for (int k = 0; k < 400 && !rose; k++) begin
          @(negedge clk);
          if (ram_rd_addr == {lb, 10'd99}) t99 = k;
          if (s_ready) begin
            rose = 1'b1;
            chk("release_to_s_ready", k - t99, 2);
          end
        end
        chk("s_ready_returned", rose, 1);
      end
    join
    drain();

    rdy_pct = 50;
    for (int i = 0; i < 20; i++) send_line((i % 4 == 0) ? 1 : $urandom_range(1024, 1), 1'b1, 50);
    drain();

    rdy_pct = 0;
    repeat (2) @(posedge clk);
    #1 send_line(30, 1'b1, 100);
    send_line(30, 1'b1, 100);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_last", m_last, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_wr_en", ram_wr_en, 0);
    chk("midrst_rd_addr", ram_rd_addr, 0);
    chk("midrst_trunc", trunc_err, 0);
    exp_q.delete();
    wb = 1'b0;
    line_idx = 0;
    rdy_pct = 100;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_s_ready_init", s_ready, 0);
    @(posedge clk);
    #1 chk("rel_s_ready_fill", s_ready, 1);
    repeat (10) @(posedge clk);
    #1 chk("no_stale_output", m_valid, 0);
    send_line(20, 1'b1, 100);
    drain();
    repeat (5) @(posedge clk);
    #1 chk("idle_at_end", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
